// File: rtl/shiftreg_pkg.sv
// Shared op codes, FSM states and op classification for the shiftreg_param slice.
package shiftreg_pkg;

    localparam logic [2:0] OP_SHL_SIN = 3'b000;
    localparam logic [2:0] OP_SHR_SIN = 3'b001;
    localparam logic [2:0] OP_LSR     = 3'b010;
    localparam logic [2:0] OP_LSL     = 3'b011;
    localparam logic [2:0] OP_JOHN_L  = 3'b100;
    localparam logic [2:0] OP_JOHN_R  = 3'b101;
    localparam logic [2:0] OP_LOAD    = 3'b110;
    localparam logic [2:0] OP_ROTR    = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic is_left_op(input logic [2:0] op);
        return (op == OP_SHL_SIN) || (op == OP_LSL) || (op == OP_JOHN_L);
    endfunction

endpackage

// File: rtl/shiftreg_step.sv
// One step of the universal shift register: next value and the bit shifted out.
module shiftreg_step
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [2:0]       op_i,
    input  logic             sin_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_o,
    output logic             shifted_o
);

    always_comb begin
        next_o    = cur_i;
        // Meaningless for LOAD; the caller leaves sout untouched for that op.
        shifted_o = is_left_op(op_i) ? cur_i[WIDTH-1] : cur_i[0];
        unique case (op_i)
            OP_SHL_SIN: next_o = {cur_i[WIDTH-2:0], sin_i};
            OP_SHR_SIN: next_o = {sin_i, cur_i[WIDTH-1:1]};
            OP_LSR:     next_o = {1'b0, cur_i[WIDTH-1:1]};
            OP_LSL:     next_o = {cur_i[WIDTH-2:0], 1'b0};
            OP_JOHN_L:  next_o = {cur_i[WIDTH-2:0], ~cur_i[WIDTH-1]};
            OP_JOHN_R:  next_o = {~cur_i[0], cur_i[WIDTH-1:1]};
            OP_LOAD:    next_o = data_i;
            OP_ROTR:    next_o = {cur_i[0], cur_i[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shiftreg_param.sv
// Multi-step universal shift register with start/busy/done command interface.
// Define SHIFTREG_PARAM_BARREL_EN to complete every command in one cycle.
module shiftreg_param
    import shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] datain,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] out_q;
    logic             sout_q;
    logic             done_q;

    assign out  = out_q;
    assign sout = sout_q;
    assign done = done_q;

`ifdef SHIFTREG_PARAM_BARREL_EN

    localparam int unsigned MAXA = (1 << AMT_W) - 1;

    // Stage k holds the result of k sequential steps, so amt selects the answer.
    logic [WIDTH-1:0] stg_out [0:MAXA];
    logic             stg_bit [0:MAXA];

    assign stg_out[0] = out_q;
    assign stg_bit[0] = sout_q;

    for (genvar k = 1; k <= MAXA; k++) begin : g_stage
        shiftreg_step #(.WIDTH(WIDTH)) u_step (
            .cur_i     (stg_out[k-1]),
            .op_i      (op),
            .sin_i     (sin),
            .data_i    (datain),
            .next_o    (stg_out[k]),
            .shifted_o (stg_bit[k])
        );
    end

    assign busy = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            sout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                done_q <= 1'b1;
                if (op == OP_LOAD) begin
                    out_q <= datain;
                end else if (amt != '0) begin
                    out_q  <= stg_out[amt];
                    sout_q <= stg_bit[amt];
                end
            end
        end
    end

`else

    state_e           state_q;
    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] cnt_d;
    logic [2:0]       op_q;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] step_out;
    logic             step_bit;

    // The accepting edge uses the live op; later steps use the latched copy.
    assign op_sel = (state_q == S_RUN) ? op_q : op;
    assign cnt_d  = cnt_q - AMT_W'(1);
    assign busy   = (state_q == S_RUN);

    shiftreg_step #(.WIDTH(WIDTH)) u_step (
        .cur_i     (out_q),
        .op_i      (op_sel),
        .sin_i     (sin),
        .data_i    (datain),
        .next_o    (step_out),
        .shifted_o (step_bit)
    );

    // cnt holds steps still to run after the current one; the step that
    // brings it to zero is the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_SHL_SIN;
            out_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_LOAD) begin
                            out_q  <= datain;
                            done_q <= 1'b1;
                        end else if (amt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            out_q  <= step_out;
                            sout_q <= step_bit;
                            op_q   <= op;
                            cnt_q  <= amt - AMT_W'(1);
                            if (amt == AMT_W'(1)) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end
                    end
                end
                S_RUN: begin
                    out_q  <= step_out;
                    sout_q <= step_bit;
                    cnt_q  <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_shiftreg_param.sv
// Self-checking bench for shiftreg_param: vector table plus scoreboard of command results.
module tb_shiftreg_param;
    import shiftreg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] datain;
    logic       sin;
    logic [7:0] out;
    logic       sout;
    logic       busy;
    logic       done;

    shiftreg_param #(.WIDTH(8), .AMT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .datain (datain),
        .sin    (sin),
        .out    (out),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  out;
        logic        sout;
        int unsigned lat;
        int unsigned bsy;
        int unsigned ncyc0;
        int unsigned nbusy0;
        string       name;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] amt;
        logic [7:0] din;
        logic       sin;
        logic [7:0] eo;
        logic       es;
    } vec_t;

    exp_t        scb[$];
    vec_t        tbl[17];
    int unsigned checks   = 0;
    int unsigned errors   = 0;
    int unsigned exp_done = 0;
    int unsigned ncyc     = 0;
    int unsigned nbusy    = 0;
    int unsigned ndone    = 0;

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (busy) nbusy <= nbusy + 1;
        if (done) ndone <= ndone + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                         input logic s, input logic [7:0] eo, input logic es, input string nm);
        exp_t e;
        e.out  = eo;
        e.sout = es;
        e.name = nm;
`ifdef SHIFTREG_PARAM_BARREL_EN
        e.lat = 0;
`else
        e.lat = (o == OP_LOAD || a <= 4'd1) ? 0 : int'(a) - 1;
`endif
        e.bsy    = e.lat;
        e.ncyc0  = ncyc;
        e.nbusy0 = nbusy;
        scb.push_back(e);
        exp_done++;
        op = o; amt = a; datain = d; sin = s; start = 1'b1;
        tick();
        start = 1'b0;
        op    = 3'($urandom);
        amt   = 4'($urandom);
    endtask

    task automatic wait_done();
        int unsigned guard = 0;
        exp_t e;
        while (!done && guard < 64) begin
            tick();
            guard++;
        end
        if (scb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got done with no pending command");
            return;
        end
        e = scb.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 64 cycles", e.name);
            return;
        end
        chk({e.name, "_out"},  32'(out),  32'(e.out));
        chk({e.name, "_sout"}, 32'(sout), 32'(e.sout));
        chk({e.name, "_lat"},  ncyc - e.ncyc0 - 1, e.lat);
        chk({e.name, "_busy"}, nbusy - e.nbusy0, e.bsy);
    endtask

    task automatic run_cmd(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                           input logic s, input logic [7:0] eo, input logic es, input string nm);
        issue(o, a, d, s, eo, es, nm);
        wait_done();
    endtask

    initial begin
        int unsigned d0;

        tbl[0]  = '{OP_LOAD,    4'd7,  8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[1]  = '{OP_ROTR,    4'd3,  8'h00, 1'b0, 8'hB4, 1'b1};
        tbl[2]  = '{OP_LOAD,    4'd0,  8'h00, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{OP_JOHN_L,  4'd8,  8'h00, 1'b0, 8'hFF, 1'b0};
        tbl[4]  = '{OP_JOHN_L,  4'd8,  8'h00, 1'b0, 8'h00, 1'b1};
        tbl[5]  = '{OP_LOAD,    4'd3,  8'h81, 1'b0, 8'h81, 1'b1};
        tbl[6]  = '{OP_LSL,     4'd0,  8'h00, 1'b0, 8'h81, 1'b1};
        tbl[7]  = '{OP_SHL_SIN, 4'd2,  8'h00, 1'b1, 8'h07, 1'b0};
        tbl[8]  = '{OP_SHR_SIN, 4'd3,  8'h00, 1'b0, 8'h00, 1'b1};
        tbl[9]  = '{OP_LOAD,    4'd1,  8'h96, 1'b0, 8'h96, 1'b1};
        tbl[10] = '{OP_JOHN_R,  4'd1,  8'h00, 1'b0, 8'hCB, 1'b0};
        tbl[11] = '{OP_LSR,     4'd4,  8'h00, 1'b0, 8'h0C, 1'b1};
        tbl[12] = '{OP_LOAD,    4'd0,  8'hF0, 1'b0, 8'hF0, 1'b1};
        tbl[13] = '{OP_LSL,     4'd15, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[14] = '{OP_LOAD,    4'd0,  8'hF0, 1'b0, 8'hF0, 1'b0};
        tbl[15] = '{OP_ROTR,    4'd9,  8'h00, 1'b0, 8'h78, 1'b0};
        tbl[16] = '{OP_SHR_SIN, 4'd10, 8'h00, 1'b1, 8'hFF, 1'b1};

        rst_n = 1'b0; start = 1'b0; op = '0; amt = '0; datain = '0; sin = 1'b0;
        tick();
        tick();
        chk("reset_out",  32'(out),  32'h00);
        chk("reset_sout", 32'(sout), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            run_cmd(tbl[i].op, tbl[i].amt, tbl[i].din, tbl[i].sin, tbl[i].eo, tbl[i].es,
                    $sformatf("vec%0d", i));
        end
        run_cmd(OP_LSR, 4'd15, 8'h00, 1'b0, 8'h00, 1'b0, "lsr15");

`ifndef SHIFTREG_PARAM_BARREL_EN
        run_cmd(OP_LOAD, 4'd0, 8'h81, 1'b0, 8'h81, 1'b0, "load81");
        issue(OP_LSR, 4'd5, 8'h00, 1'b0, 8'h04, 1'b0, "lsr_ignore_start");
        tick();
        chk("busy_mid_run", 32'(busy), 32'h1);
        op = OP_LOAD; datain = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_ignored_start", 32'(busy), 32'h1);
        wait_done();

        run_cmd(OP_LOAD, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, "load00");
        op = OP_SHL_SIN; amt = 4'd6; sin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; op = OP_LOAD; amt = 4'd0;
        tick();
        tick();
        chk("abort_out_before", 32'(out),  32'h07);
        chk("abort_busy_before", 32'(busy), 32'h1);
        d0 = ndone;
        rst_n = 1'b0;
        #1;
        chk("abort_async_out",  32'(out),  32'h00);
        chk("abort_async_sout", 32'(sout), 32'h0);
        chk("abort_async_busy", 32'(busy), 32'h0);
        chk("abort_async_done", 32'(done), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_done", ndone, d0);
        run_cmd(OP_LOAD, 4'd0, 8'h3C, 1'b0, 8'h3C, 1'b0, "post_abort_load");
        run_cmd(OP_ROTR, 4'd2, 8'h00, 1'b0, 8'h0F, 1'b0, "post_abort_rotr");
`endif

        for (int i = 0; i < 3; i++) tick();
        chk("done_pulse_total", ndone, exp_done);
        chk("scoreboard_drained", scb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftreg_param.md
Name: shiftreg_param

Overview:
- Parametrised, multi-step universal shift register. It is the next generation of the team's 8-bit, 8-op shift register.
- Generalised to WIDTH bits. Adds a start/busy/done command interface that applies the selected op AMT times, one step per clock.
- Sits between a bus-side controller, which issues commands, and serial links or datapath registers, which consume `out` and `sout`.

Parameters:
- WIDTH, 8: register width in bits (minimum 2).
- AMT_W, 4: width of the repeat-count input. Maximum repeat is 2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  command strobe; sampled only when idle
- op  input  3  operation code, latched on an accepted start
- amt  input  AMT_W  number of steps, latched on an accepted start
- datain  input  WIDTH  parallel load value, used by op LOAD
- sin  input  1  serial input; sampled live on every executed step
- out  output  WIDTH  register contents
- sout  output  1  last bit shifted out
- busy  output  1  high while a command is executing
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset values: out=0, sout=0, busy=0, done=0, FSM=IDLE. Reset is asynchronous.
- Op codes:
  - 000 SHL_SIN: {out[W-2:0], sin}
  - 001 SHR_SIN: {sin, out[W-1:1]}
  - 010 LSR: {0, out[W-1:1]}
  - 011 LSL: {out[W-2:0], 0}
  - 100 JOHN_L: {out[W-2:0], ~out[W-1]}
  - 101 JOHN_R: {~out[0], out[W-1:1]}
  - 110 LOAD: datain
  - 111 ROTR: {out[0], out[W-1:1]}
- sout on each executed step:
  - Left ops (000, 011, 100): sout <= out[W-1].
  - Right ops (001, 010, 101, 111): sout <= out[0].
  - LOAD: sout unchanged.
  - When no step executes, sout holds.
- FSM states IDLE and RUN. A down-counter `cnt` of AMT_W bits is latched with amt.
- IDLE with start=1 and op=LOAD:
  - out <= datain on that edge.
  - done=1 on the next cycle.
  - amt is ignored.
  - The FSM stays in IDLE.
- IDLE with start=1 and amt=0: no change to out or sout; done pulses on the next cycle; the FSM stays in IDLE.
- IDLE with start=1 and amt>0:
  - The first step executes on the accepting edge; the FSM enters RUN with cnt=amt-1.
  - busy=1 while in RUN.
  - Each RUN edge executes one step and decrements cnt.
  - When a step executes with cnt==0, the FSM returns to IDLE and busy=0. done=1 for exactly the following cycle.
- Latency: an N-step command finishes its last step at accept+N-1 edges. done is visible N cycles after accept.
- start while busy=1 is ignored (not queued). start on the same cycle that done is high is accepted normally.
- op and amt changes during RUN have no effect, because the latched copies are used. Changes to sin and datain take effect immediately (sin is live).
- rst_n asserted mid-command: the command aborts immediately and all reset values are applied. No done is produced.
- The counter does not wrap: amt = 2^AMT_W-1 gives exactly that many steps.

Optional Feature:
- Macro: SHIFTREG_PARAM_BARREL_EN.
- When defined, every command completes on the accepting edge with a single barrel-shift of amt positions:
  - SHL_SIN and SHR_SIN fill with replicated sin.
  - JOHN_L and JOHN_R apply amt sequential-equivalent steps.
  - sout equals the last bit shifted out; for amt > WIDTH, the LSL/LSR fill value.
  - busy stays 0. done pulses on the next cycle.
- When not defined, the serial multi-cycle behaviour above applies.
- Final out and sout are identical in both builds for constant sin.

Decomposition:
- Package shiftreg_pkg holds:
  - localparam op codes OP_SHL_SIN..OP_ROTR (3 bits);
  - FSM state encodings S_IDLE and S_RUN;
  - a function is_left_op(op).
- Sub-module shiftreg_step (combinational, parametrised by WIDTH) computes next_out and shifted_bit from (out, op, sin, datain).
  - The serial path instantiates it once.
  - The barrel path reuses its op decode.

Test Plan (WIDTH=8, AMT_W=4):
- Reset then LOAD datain=8'hA5 -> out=A5 after the edge; done pulses 1 cycle later; busy never high.
- out=A5, op=ROTR, amt=3 -> busy high 2 cycles; out=B4 after the 3rd step; sout=1 (last bit out); done pulse.
- out=00, op=JOHN_L, amt=8 -> out=FF; a further amt=8 gives out=00; done once per command.
- out=81, op=LSL, amt=0 -> out stays 81; sout unchanged; done pulse next cycle.
- During RUN (LSR, amt=5), assert start with op=LOAD -> ignored; 5 steps complete; out=8'h81>>5=04.
- During RUN (SHL_SIN, amt=6, sin=1), drop rst_n at step 3 -> out=00, busy=0, no done. After release, a new command works normally.
